// File: rtl/button_pkg.sv
// Shared types and constants for the push-button conditioning path.
package button_pkg;

  // Button indices within the {U, D, L, R} vector; higher index wins arbitration.
  localparam int unsigned BTN_U = 3;
  localparam int unsigned BTN_D = 2;
  localparam int unsigned BTN_L = 1;
  localparam int unsigned BTN_R = 0;

  // Per-button debounce state.
  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } deb_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Single-button debouncer: accepts a level change only after it holds for
// DEBOUNCE_CYCLES consecutive cycles; flags the accepted press for one cycle.
module btn_debounce
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sync_in,
  output logic level,
  output logic press_evt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  deb_state_t       r_state;
  deb_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_level;
  logic             w_level_nxt;
  logic             w_cnt_done;

  assign w_cnt_done = (r_cnt == CNT_LAST);

  // State, counter and accepted level registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RELEASED;
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
    end
  end

  // Next state; the counter is cleared on every state entry so it never wraps.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_level_nxt = r_level;
    press_evt   = 1'b0;
    case (r_state)
      RELEASED: begin
        if (sync_in) begin
          w_state_nxt = PRESS_CHK;
          w_cnt_nxt   = '0;
        end
      end
      PRESS_CHK: begin
        if (!sync_in) begin
          w_state_nxt = RELEASED;
          w_cnt_nxt   = '0;
        end else if (w_cnt_done) begin
          w_state_nxt = PRESSED;
          w_cnt_nxt   = '0;
          w_level_nxt = 1'b1;
          press_evt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!sync_in) begin
          w_state_nxt = RELEASE_CHK;
          w_cnt_nxt   = '0;
        end
      end
      RELEASE_CHK: begin
        if (sync_in) begin
          w_state_nxt = PRESSED;
          w_cnt_nxt   = '0;
        end else if (w_cnt_done) begin
          w_state_nxt = RELEASED;
          w_cnt_nxt   = '0;
          w_level_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = RELEASED;
        w_cnt_nxt   = '0;
        w_level_nxt = 1'b0;
      end
    endcase
  end

  assign level = r_level;

endmodule

// File: rtl/button_conditioner.sv
// Synchronizes and debounces the direction buttons, then turns each accepted
// press into a single one-hot strobe, locking out further presses until every
// button is released.
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned N_BTN           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse,
  output logic             busy
);

  logic [N_BTN-1:0] r_sync1;
  logic [N_BTN-1:0] r_sync2;
  logic [N_BTN-1:0] w_level;
  logic [N_BTN-1:0] w_press_evt;
  logic [N_BTN-1:0] w_grant;
  logic [N_BTN-1:0] r_pulse;
  logic             r_lock;

  // Two-flop synchronizer for the asynchronous button pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn_in;
      r_sync2 <= r_sync1;
    end
  end

  // One debouncer per button.
  for (genvar g = 0; g < N_BTN; g++) begin : g_deb
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_deb (
      .clk      (clk),
      .rst_n    (rst_n),
      .sync_in  (r_sync2[g]),
      .level    (w_level[g]),
      .press_evt(w_press_evt[g])
    );
  end

  // Fixed priority: the highest-index press event wins, others are dropped.
  always_comb begin
    w_grant = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (w_press_evt[i]) begin
        w_grant    = '0;
        w_grant[i] = 1'b1;
      end
    end
  end

  // Strobe register and lockout; lock drops once all debounced levels are low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pulse <= '0;
      r_lock  <= 1'b0;
    end else if (r_lock) begin
      r_pulse <= '0;
      if (w_level == '0) begin
        r_lock <= 1'b0;
      end
    end else begin
      r_pulse <= w_grant;
      if (w_press_evt != '0) begin
        r_lock <= 1'b1;
      end
    end
  end

  assign btn_level = w_level;
  assign btn_pulse = r_pulse;
  assign busy      = r_lock;

endmodule
